// File: rtl/param_ram_writer_pkg.sv
// Shared widths, field masks and FSM state type for the parameter RAM write path.
// The MIDI decoder imports the same field masks so both ends agree on bit positions.
package param_ram_writer_pkg;

  localparam int DEF_VOICE_W     = 8;
  localparam int DEF_PARAM_W     = 16;
  localparam int DEF_FIFO_DEPTH  = 8;
  localparam int DEF_MAX_PER_WIN = 4;

  localparam logic [15:0] PMASK_WAVE    = 16'h0003;
  localparam logic [15:0] PMASK_ATTACK  = 16'h001C;
  localparam logic [15:0] PMASK_DECAY   = 16'h00E0;
  localparam logic [15:0] PMASK_SUSTAIN = 16'h0F00;
  localparam logic [15:0] PMASK_RELEASE = 16'hF000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RD,
    ST_WAIT,
    ST_WR,
    ST_DONE,
    ST_HOLD
  } wr_state_t;

endpackage

// File: rtl/param_ram_writer_if.sv
// Bundle of the decoder event port, the voice-controller window handshake and the RAM port.
interface param_ram_writer_if
  import param_ram_writer_pkg::*;
#(
  parameter int VOICE_W = DEF_VOICE_W,
  parameter int PARAM_W = DEF_PARAM_W
);

  logic               evt_valid;
  logic               evt_ready;
  logic [VOICE_W-1:0] evt_voice;
  logic [PARAM_W-1:0] evt_mask;
  logic [PARAM_W-1:0] evt_data;
  logic               win_req;
  logic               win_done;
  logic [VOICE_W-1:0] ram_address;
  logic [PARAM_W-1:0] ram_data;
  logic               ram_we;
  logic [PARAM_W-1:0] ram_q;

  modport slave (
    input  evt_valid, evt_voice, evt_mask, evt_data, win_req, ram_q,
    output evt_ready, win_done, ram_address, ram_data, ram_we
  );

  modport master (
    output evt_valid, evt_voice, evt_mask, evt_data, win_req, ram_q,
    input  evt_ready, win_done, ram_address, ram_data, ram_we
  );

endinterface

// File: rtl/param_ram_writer_fifo.sv
// Synchronous update buffer; show-ahead head entry and registered full/empty flags.
module param_ram_writer_fifo #(
  parameter int WIDTH = 40,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr, rd_ptr, wr_nxt, rd_nxt;
  logic             do_push, do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign wr_nxt  = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_nxt  = rd_ptr + {{AW{1'b0}}, do_pop};
  assign head    = mem[rd_ptr[AW-1:0]];
  assign count   = wr_ptr - rd_ptr;

  // Extra pointer MSB separates full (MSBs differ) from empty (MSBs equal).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      full   <= 1'b0;
      empty  <= 1'b1;
    end else begin
      wr_ptr <= wr_nxt;
      rd_ptr <= rd_nxt;
      empty  <= (wr_nxt == rd_nxt);
      full   <= (wr_nxt[AW] != rd_nxt[AW]) && (wr_nxt[AW-1:0] == rd_nxt[AW-1:0]);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/param_ram_writer.sv
// Buffers parameter updates and commits them as masked read-modify-writes inside the
// update window granted by the voice controller.
//
// state | meaning
// IDLE  | RAM not granted; waiting for win_req
// RD    | drive head entry's voice address
// WAIT  | RAM samples the address
// WR    | merge ram_q with head field, write, pop
// DONE  | pulse win_done, hand the RAM back
// HOLD  | wait for win_req to drop (one window per request)
module param_ram_writer
  import param_ram_writer_pkg::*;
#(
  parameter int VOICE_W     = DEF_VOICE_W,
  parameter int PARAM_W     = DEF_PARAM_W,
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int MAX_PER_WIN = DEF_MAX_PER_WIN
) (
  input  logic              clk,
  input  logic              reset,
  param_ram_writer_if.slave bus
);

  localparam int ENTRY_W = VOICE_W + 2 * PARAM_W;
  localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;
  localparam int N_W     = $clog2(MAX_PER_WIN + 1);

  wr_state_t          state;
  logic [N_W-1:0]     n;
  logic               full, empty, push, pop, last_entry;
  logic [ENTRY_W-1:0] head;
  logic [CNT_W-1:0]   count;
  logic [VOICE_W-1:0] head_voice;
  logic [PARAM_W-1:0] head_mask, head_data, merged;
  logic [VOICE_W-1:0] ram_address_r;
  logic [PARAM_W-1:0] ram_data_r;
  logic               ram_we_r, win_done_r;

  assign push          = bus.evt_valid & ~full;
  assign pop           = (state == ST_WR);
  assign bus.evt_ready = ~full;

  assign {head_voice, head_mask, head_data} = head;
  assign merged = (bus.ram_q & ~head_mask) | (head_data & head_mask);
  // A push landing on the same edge as the pop keeps the window going.
  assign last_entry = (count == CNT_W'(1)) && !push;

  param_ram_writer_fifo #(
    .WIDTH (ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   ({bus.evt_voice, bus.evt_mask, bus.evt_data}),
    .head  (head),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state         <= ST_IDLE;
      n             <= '0;
      ram_address_r <= '0;
      ram_data_r    <= '0;
      ram_we_r      <= 1'b0;
      win_done_r    <= 1'b0;
    end else begin
      win_done_r <= 1'b0;
      case (state)
        ST_IDLE: begin
          ram_we_r <= 1'b0;
          n        <= '0;
          if (bus.win_req) state <= empty ? ST_DONE : ST_RD;
        end
        ST_RD: begin
          ram_we_r <= 1'b0;
          if (!bus.win_req) begin
            state <= ST_IDLE;
          end else begin
            ram_address_r <= head_voice;
            state         <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state <= bus.win_req ? ST_WR : ST_IDLE;
        end
        ST_WR: begin
          // An abort arriving here still completes this one write.
          ram_data_r <= merged;
          ram_we_r   <= 1'b1;
          n          <= n + N_W'(1);
          if (!bus.win_req)
            state <= ST_IDLE;
          else if (last_entry || n == N_W'(MAX_PER_WIN - 1))
            state <= ST_DONE;
          else
            state <= ST_RD;
        end
        ST_DONE: begin
          ram_we_r <= 1'b0;
          if (!bus.win_req) begin
            state <= ST_IDLE;
          end else begin
            win_done_r <= 1'b1;
            state      <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          ram_we_r <= 1'b0;
          if (!bus.win_req) state <= ST_IDLE;
        end
        default: begin
          ram_we_r <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ram_address = ram_address_r;
  assign bus.ram_data    = ram_data_r;
  assign bus.ram_we      = ram_we_r;
  assign bus.win_done    = win_done_r;

endmodule

// File: tb/tb_param_ram_writer.sv
// Directed bench for param_ram_writer with a write-first, 1-cycle-read RAM model.
module tb_param_ram_writer;
  import param_ram_writer_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [15:0] ram_mem [256] = '{default: '0};
  logic        pl_go = 1'b0;
  logic [7:0]  pl_addr = '0;
  logic [15:0] pl_val = '0;
  logic [23:0] wr_log [$];

  param_ram_writer_if bus ();

  param_ram_writer dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_go) ram_mem[pl_addr] <= pl_val;
    else if (bus.ram_we) ram_mem[bus.ram_address] <= bus.ram_data;
    bus.ram_q <= (bus.ram_we && !pl_go) ? bus.ram_data : ram_mem[bus.ram_address];
    if (bus.ram_we) wr_log.push_back({bus.ram_address, bus.ram_data});
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [7:0] a, input logic [15:0] v);
    pl_addr = a;
    pl_val  = v;
    pl_go   = 1'b1;
    tick();
    pl_go   = 1'b0;
  endtask

  task automatic push_evt(input logic [7:0] v, input logic [15:0] m, input logic [15:0] d);
    int c;
    c = 0;
    bus.evt_voice = v;
    bus.evt_mask  = m;
    bus.evt_data  = d;
    bus.evt_valid = 1'b1;
    while (!bus.evt_ready && c < 100) begin
      tick();
      c++;
    end
    if (c >= 100) begin
      total_cnt++;
      $display("FAIL push_timeout: evt_ready stuck low for voice %0d", v);
    end
    tick();
    bus.evt_valid = 1'b0;
  endtask

  task automatic run_window(output int cyc);
    int  c;
    bit  seen;
    c = 0;
    seen = 1'b0;
    bus.win_req = 1'b1;
    while (!seen && c < 200) begin
      tick();
      c++;
      if (bus.win_done) seen = 1'b1;
    end
    total_cnt++;
    if (!seen) $display("FAIL win_done_timeout: no win_done after %0d cycles", c);
    else pass_cnt++;
    cyc = c;
    bus.win_req = 1'b0;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (bus.ram_we !== 1'b0) $display("FAIL rst_we: got %b want 0", bus.ram_we);
    else pass_cnt++;
    total_cnt++;
    if (bus.ram_address !== 8'h00) $display("FAIL rst_addr: got %h want 00", bus.ram_address);
    else pass_cnt++;
    total_cnt++;
    if (bus.ram_data !== 16'h0000) $display("FAIL rst_data: got %h want 0000", bus.ram_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.win_done !== 1'b0) $display("FAIL rst_win_done: got %b want 0", bus.win_done);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    total_cnt++;
    if (bus.evt_ready !== 1'b1) $display("FAIL rst_ready: got %b want 1", bus.evt_ready);
    else pass_cnt++;
  endtask

  task automatic test_single();
    int cyc;
    wr_log.delete();
    preload(8'd5, 16'hFFFF);
    push_evt(8'd5, PMASK_ATTACK, 16'h0008);
    run_window(cyc);
    total_cnt++;
    if (cyc != 5) $display("FAIL single_latency: got %0d want 5", cyc);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 1) $display("FAIL single_nwrites: got %0d want 1", wr_log.size());
    else pass_cnt++;
    total_cnt++;
    if (ram_mem[5] !== 16'hFFEB) $display("FAIL single_ram5: got %h want FFEB", ram_mem[5]);
    else pass_cnt++;
    total_cnt++;
    if (bus.ram_address !== 8'd5) $display("FAIL single_addr_hold: got %h want 05", bus.ram_address);
    else pass_cnt++;
  endtask

  task automatic test_empty_window();
    int c;
    int pulses;
    wr_log.delete();
    c = 0;
    pulses = 0;
    bus.win_req = 1'b1;
    while (!bus.win_done && c < 50) begin
      tick();
      c++;
    end
    total_cnt++;
    if (c != 2) $display("FAIL empty_latency: got %0d want 2", c);
    else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.win_done) pulses++;
    end
    total_cnt++;
    if (pulses != 0) $display("FAIL empty_double_pulse: got %0d extra pulses want 0", pulses);
    else pass_cnt++;
    bus.win_req = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (wr_log.size() != 0) $display("FAIL empty_we: got %0d writes want 0", wr_log.size());
    else pass_cnt++;
  endtask

  task automatic test_masks();
    int cyc;
    preload(8'd10, 16'h1234);
    preload(8'd11, 16'h5555);
    preload(8'd12, 16'h0000);
    push_evt(8'd10, 16'h0000, 16'hFFFF);
    push_evt(8'd11, 16'hFFFF, 16'hABCD);
    push_evt(8'd12, 16'h00F0, 16'hFFFF);
    run_window(cyc);
    total_cnt++;
    if (cyc != 11) $display("FAIL masks_latency: got %0d want 11", cyc);
    else pass_cnt++;
    total_cnt++;
    if (ram_mem[10] !== 16'h1234) $display("FAIL mask_zero: got %h want 1234", ram_mem[10]);
    else pass_cnt++;
    total_cnt++;
    if (ram_mem[11] !== 16'hABCD) $display("FAIL mask_ones: got %h want ABCD", ram_mem[11]);
    else pass_cnt++;
    total_cnt++;
    if (ram_mem[12] !== 16'h00F0) $display("FAIL mask_outside: got %h want 00F0", ram_mem[12]);
    else pass_cnt++;
  endtask

  task automatic test_max_per_win();
    int cyc;
    wr_log.delete();
    for (int i = 0; i < 6; i++) push_evt(8'(20 + i), 16'hFFFF, 16'(16'h0100 + i));
    run_window(cyc);
    total_cnt++;
    if (cyc != 14) $display("FAIL max_win1_latency: got %0d want 14", cyc);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 4) $display("FAIL max_win1_count: got %0d want 4", wr_log.size());
    else pass_cnt++;
    run_window(cyc);
    total_cnt++;
    if (cyc != 8) $display("FAIL max_win2_latency: got %0d want 8", cyc);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 6) begin
      $display("FAIL max_total_count: got %0d want 6", wr_log.size());
    end else begin
      pass_cnt++;
      for (int i = 0; i < 6; i++) begin
        total_cnt++;
        if (wr_log[i] !== {8'(20 + i), 16'(16'h0100 + i)})
          $display("FAIL max_order[%0d]: got %h want %h", i, wr_log[i], {8'(20 + i), 16'(16'h0100 + i)});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_full();
    int c;
    int cyc;
    wr_log.delete();
    for (int i = 0; i < 8; i++) push_evt(8'(30 + i), 16'hFFFF, 16'(16'hA000 + i));
    total_cnt++;
    if (bus.evt_ready !== 1'b0) $display("FAIL full_ready: got %b want 0", bus.evt_ready);
    else pass_cnt++;
    bus.evt_voice = 8'd38;
    bus.evt_mask  = 16'hFFFF;
    bus.evt_data  = 16'hA008;
    bus.evt_valid = 1'b1;
    for (int i = 0; i < 3; i++) tick();
    total_cnt++;
    if (bus.evt_ready !== 1'b0) $display("FAIL full_hold: got %b want 0", bus.evt_ready);
    else pass_cnt++;
    bus.win_req = 1'b1;
    c = 0;
    while (!bus.evt_ready && c < 50) begin
      tick();
      c++;
    end
    total_cnt++;
    if (c != 4) $display("FAIL full_free_slot: got %0d cycles want 4", c);
    else pass_cnt++;
    tick();
    c++;
    bus.evt_valid = 1'b0;
    while (!bus.win_done && c < 100) begin
      tick();
      c++;
    end
    total_cnt++;
    if (c != 14) $display("FAIL full_win1_latency: got %0d want 14", c);
    else pass_cnt++;
    bus.win_req = 1'b0;
    tick();
    tick();
    run_window(cyc);
    total_cnt++;
    if (cyc != 14) $display("FAIL full_win2_latency: got %0d want 14", cyc);
    else pass_cnt++;
    run_window(cyc);
    total_cnt++;
    if (cyc != 5) $display("FAIL full_win3_latency: got %0d want 5", cyc);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 9) begin
      $display("FAIL full_total_count: got %0d want 9", wr_log.size());
    end else begin
      pass_cnt++;
      for (int i = 0; i < 9; i++) begin
        total_cnt++;
        if (wr_log[i] !== {8'(30 + i), 16'(16'hA000 + i)})
          $display("FAIL full_order[%0d]: got %h want %h", i, wr_log[i], {8'(30 + i), 16'(16'hA000 + i)});
        else pass_cnt++;
      end
    end
  endtask

  task automatic test_back_to_back();
    int cyc;
    preload(8'd3, 16'h0000);
    push_evt(8'd3, 16'h000F, 16'h0005);
    push_evt(8'd3, 16'h00F0, 16'h0060);
    run_window(cyc);
    total_cnt++;
    if (cyc != 8) $display("FAIL b2b_latency: got %0d want 8", cyc);
    else pass_cnt++;
    total_cnt++;
    if (ram_mem[3] !== 16'h0065) $display("FAIL b2b_ram3: got %h want 0065", ram_mem[3]);
    else pass_cnt++;
  endtask

  task automatic test_abort();
    int cyc;
    int pulses;
    wr_log.delete();
    preload(8'd7, 16'h0000);
    push_evt(8'd7, 16'hFFFF, 16'h1111);
    bus.win_req = 1'b1;
    tick();
    tick();
    total_cnt++;
    if (bus.ram_address !== 8'd7) $display("FAIL abort_pre_addr: got %h want 07", bus.ram_address);
    else pass_cnt++;
    reset = 1'b0;
    #1;
    total_cnt++;
    if (bus.ram_address !== 8'h00) $display("FAIL abort_rst_addr: got %h want 00", bus.ram_address);
    else pass_cnt++;
    total_cnt++;
    if (bus.ram_data !== 16'h0000) $display("FAIL abort_rst_data: got %h want 0000", bus.ram_data);
    else pass_cnt++;
    total_cnt++;
    if (bus.ram_we !== 1'b0) $display("FAIL abort_rst_we: got %b want 0", bus.ram_we);
    else pass_cnt++;
    bus.win_req = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    run_window(cyc);
    total_cnt++;
    if (cyc != 2) $display("FAIL abort_rst_fifo_empty: got %0d want 2", cyc);
    else pass_cnt++;
    total_cnt++;
    if (wr_log.size() != 0) $display("FAIL abort_rst_nowrite: got %0d writes want 0", wr_log.size());
    else pass_cnt++;

    preload(8'd8, 16'h0000);
    push_evt(8'd8, 16'hFFFF, 16'h2222);
    pulses = 0;
    bus.win_req = 1'b1;
    tick();
    tick();
    bus.win_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.win_done) pulses++;
    end
    total_cnt++;
    if (wr_log.size() != 0) $display("FAIL abort_wait_nowrite: got %0d writes want 0", wr_log.size());
    else pass_cnt++;
    total_cnt++;
    if (pulses != 0) $display("FAIL abort_wait_pulse: got %0d pulses want 0", pulses);
    else pass_cnt++;
    run_window(cyc);
    total_cnt++;
    if (cyc != 5) $display("FAIL abort_retained_latency: got %0d want 5", cyc);
    else pass_cnt++;
    total_cnt++;
    if (ram_mem[8] !== 16'h2222) $display("FAIL abort_retained_ram8: got %h want 2222", ram_mem[8]);
    else pass_cnt++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.evt_valid = 1'b0;
    bus.evt_voice = '0;
    bus.evt_mask  = '0;
    bus.evt_data  = '0;
    bus.win_req   = 1'b0;
    test_reset();
    test_single();
    test_empty_window();
    test_masks();
    test_max_per_win();
    test_full();
    test_back_to_back();
    test_abort();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
